// File: rtl/scic_pkg.sv
// Shared types and widths for the CPU, memory and sequencer.
package scic_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    LOAD,
    BOOT,
    RUN
  } seq_state_t;

endpackage

// File: rtl/run_watchdog.sv
// Saturating RUN-cycle counter with an optional limit compare.
module run_watchdog
  import scic_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [DATA_W-1:0] count,
  output logic              expire
);

  // MAX_CYCLES == 0 wraps to all-ones here but is masked out of expire below.
  localparam logic [DATA_W-1:0] LastCycle = DATA_W'(MAX_CYCLES - 1);

  logic [DATA_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = (MAX_CYCLES != 0) && enable && (count_q == LastCycle);

endmodule

// File: rtl/cpu_mem_sequencer.sv
// Arbitrates the single-port memory between a host loader and the CPU, and sequences
// the CPU through reset hold, run and back to load mode on halt or watchdog expiry.
module cpu_mem_sequencer
  import scic_pkg::*;
#(
  parameter int unsigned RESET_HOLD = 2,
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              host_start,
  input  logic              host_halt,
  output logic              cpu_reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_data_out,
  output logic [DATA_W-1:0] cpu_data_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              running,
  output logic              timeout,
  output logic [DATA_W-1:0] run_cycles
);

  localparam logic [31:0] HoldLast = 32'(RESET_HOLD - 1);

  seq_state_t        state_q, state_d;
  logic [31:0]       hold_cnt_q, hold_cnt_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              timeout_q, timeout_d;
  logic              wd_clear, wd_enable, wd_expire;
  logic              host_accept;

  run_watchdog #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_run_watchdog (
    .clock (clock),
    .reset (reset),
    .clear (wd_clear),
    .enable(wd_enable),
    .count (run_cycles),
    .expire(wd_expire)
  );

  assign wd_enable = (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = timeout_q;
    wd_clear   = 1'b0;
    unique case (state_q)
      LOAD: begin
        // Start beats a simultaneous halt; halt alone is meaningless here.
        if (host_start) begin
          state_d    = BOOT;
          hold_cnt_d = '0;
          timeout_d  = 1'b0;
          wd_clear   = 1'b1;
        end
      end
      BOOT: begin
        if (host_halt) begin
          state_d = LOAD;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      RUN: begin
        if (wd_expire) begin
          timeout_d = 1'b1;
        end
        if (host_halt || wd_expire) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
    cpu_reset_d = (state_d != RUN);
  end

  always_comb begin
    host_ready = (state_q == LOAD);
    if (state_q == LOAD) begin
      mem_address = host_addr;
      mem_we      = host_valid & host_we;
      mem_wdata   = host_wdata;
    end else begin
      mem_address = cpu_address;
      // CPU outputs are undefined until it has seen reset, so BOOT never writes.
      mem_we      = (state_q == RUN) & cpu_we;
      mem_wdata   = cpu_data_out;
    end
  end

  assign host_accept = host_valid & host_ready;

  always_comb begin
    rvalid_d = host_accept & ~host_we;
    rdata_d  = rvalid_d ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= LOAD;
      hold_cnt_q  <= '0;
      cpu_reset_q <= 1'b1;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;
  assign timeout     = timeout_q;
  assign running     = (state_q == RUN);
  assign cpu_data_in = mem_rdata;

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Scoreboarded bench: the bench plays the CPU by driving its bus directly, and
// a behavioural async-read/sync-write memory sits on the mem_* port.
module tb_cpu_mem_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        host_valid, host_ready, host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata, host_rdata;
  logic        host_rvalid, host_start, host_halt;
  logic        cpu_reset;
  logic [15:0] cpu_address;
  logic        cpu_we;
  logic [31:0] cpu_data_out, cpu_data_in;
  logic [15:0] mem_address;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic        running, timeout;
  logic [31:0] run_cycles;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[0:65535];

  always #5 clock = ~clock;

  cpu_mem_sequencer #(
    .RESET_HOLD(2),
    .MAX_CYCLES(10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .host_start  (host_start),
    .host_halt   (host_halt),
    .cpu_reset   (cpu_reset),
    .cpu_address (cpu_address),
    .cpu_we      (cpu_we),
    .cpu_data_out(cpu_data_out),
    .cpu_data_in (cpu_data_in),
    .mem_address (mem_address),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .running     (running),
    .timeout     (timeout),
    .run_cycles  (run_cycles)
  );

  assign mem_rdata = mem[mem_address];
  always @(posedge clock) if (mem_we === 1'b1) mem[mem_address] <= mem_wdata;

  // Monitor: every rvalid pulse must match the oldest expected read.
  always @(negedge clock) begin
    logic [31:0] e;
    if (host_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stray_rvalid: got rvalid=1 data=0x%08h, required no response", host_rdata);
      end else begin
        e = exp_q.pop_front();
        if (host_rdata !== e) begin
          errors++;
          $display("FAIL read_data: got 0x%08h, required 0x%08h", host_rdata, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    step();
    host_valid = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input logic [15:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    host_valid = 1'b1; host_we = 1'b0; host_addr = a;
    step();
    host_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish within bound");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    reset = 1'b1; host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    host_start = 1'b0; host_halt = 1'b0;
    cpu_address = '0; cpu_we = 1'b0; cpu_data_out = '0;
    step(); step();
    @(negedge clock);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_ready", 32'(host_ready), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_rdata", host_rdata, 32'h0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_run_cycles", run_cycles, 32'd0);
    reset = 1'b0;
    step();

    // 1: host write then reads, including back-to-back
    host_write(16'h0003, 32'h12345678);
    host_write(16'h0004, 32'hCAFEF00D);
    host_read(16'h0003, 32'h12345678);
    host_read(16'h0004, 32'hCAFEF00D);
    host_read(16'h0003, 32'h12345678);
    @(negedge clock);
    check("t1_cpu_reset", 32'(cpu_reset), 32'd1);

    // 2: load program, boot through two reset-hold cycles, store, halt
    host_write(16'h0000, 32'h4000_00AA);
    host_write(16'h0001, 32'h7000_0010);
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    @(negedge clock);
    check("t2_boot1_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t2_boot1_ready", 32'(host_ready), 32'd0);
    step();
    @(negedge clock);
    check("t2_boot2_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t2_boot2_running", 32'(running), 32'd0);
    step();
    cpu_address = 16'h0000;
    @(negedge clock);
    check("t2_run_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t2_run_running", 32'(running), 32'd1);
    check("t2_fetch0", cpu_data_in, 32'h4000_00AA);
    step();
    cpu_address = 16'h0001;
    @(negedge clock);
    check("t2_fetch1", cpu_data_in, 32'h7000_0010);
    step();
    cpu_address = 16'h0010; cpu_we = 1'b1; cpu_data_out = 32'h0000_00AA;
    step();
    cpu_we = 1'b0; cpu_address = 16'h0000; host_halt = 1'b1;
    step();
    host_halt = 1'b0;
    @(negedge clock);
    check("t2_halt_running", 32'(running), 32'd0);
    check("t2_halt_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t2_run_cycles", run_cycles, 32'd4);
    host_read(16'h0010, 32'h0000_00AA);

    // 3: watchdog on a branch-to-self program
    host_write(16'h0000, 32'h9000_0000);
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (running) n++;
      else if (n > 0) break;
      step();
    end
    check("t3_run_count", 32'(n), 32'd10);
    check("t3_timeout", 32'(timeout), 32'd1);
    check("t3_run_cycles", run_cycles, 32'd10);
    check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    @(negedge clock);
    check("t3_restart_timeout", 32'(timeout), 32'd0);
    check("t3_restart_cycles", run_cycles, 32'd0);
    host_halt = 1'b1;
    step();
    host_halt = 1'b0;
    @(negedge clock);
    check("t3_boot_halt_ready", 32'(host_ready), 32'd1);
    check("t3_boot_halt_running", 32'(running), 32'd0);

    // 4: read alongside start; CPU bus gated in BOOT; host locked out in RUN
    exp_q.push_back(32'h12345678);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0003; host_start = 1'b1;
    step();
    host_valid = 1'b0; host_start = 1'b0;
    cpu_we = 1'b1; cpu_address = 16'h0020; cpu_data_out = 32'hDEADBEEF;
    @(negedge clock);
    check("t4_boot_ready", 32'(host_ready), 32'd0);
    check("t4_boot_mem_we", 32'(mem_we), 32'd0);
    step();
    @(negedge clock);
    check("t4_boot2_mem_we", 32'(mem_we), 32'd0);
    step();
    cpu_we = 1'b0; cpu_address = 16'h0000;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h0030; host_wdata = 32'h0BADF00D;
    @(negedge clock);
    check("t4_run_ready", 32'(host_ready), 32'd0);
    check("t4_run_mem_we", 32'(mem_we), 32'd0);
    step();
    @(negedge clock);
    check("t4_run_mem_addr", 32'(mem_address), 32'h0000);
    host_valid = 1'b0; host_we = 1'b0; host_halt = 1'b1;
    step();
    host_halt = 1'b0;
    host_read(16'h0030, 32'h0);
    host_read(16'h0020, 32'h0);

    // 5: halt on a store cycle, then reset mid-RUN and mid-read
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    step(); step();
    cpu_address = 16'h0040; cpu_we = 1'b1; cpu_data_out = 32'h55AA55AA; host_halt = 1'b1;
    step();
    cpu_we = 1'b0; cpu_address = 16'h0000; host_halt = 1'b0;
    @(negedge clock);
    check("t5_halt_running", 32'(running), 32'd0);
    check("t5_halt_run_cycles", run_cycles, 32'd1);
    host_read(16'h0040, 32'h55AA55AA);
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("t5_rst_running", 32'(running), 32'd0);
    check("t5_rst_run_cycles", run_cycles, 32'd0);
    check("t5_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t5_rst_ready", 32'(host_ready), 32'd1);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0003; reset = 1'b1;
    step();
    reset = 1'b0; host_valid = 1'b0;
    @(negedge clock);
    check("t5_rst_rvalid", 32'(host_rvalid), 32'd0);
    check("t5_rst_rdata", host_rdata, 32'h0);

    // 6: halt ignored in LOAD, start+halt boots, start ignored in RUN
    host_halt = 1'b1;
    step();
    host_halt = 1'b0;
    @(negedge clock);
    check("t6_halt_load_ready", 32'(host_ready), 32'd1);
    check("t6_halt_load_cpu_reset", 32'(cpu_reset), 32'd1);
    host_start = 1'b1; host_halt = 1'b1;
    step();
    host_start = 1'b0; host_halt = 1'b0;
    @(negedge clock);
    check("t6_both_ready", 32'(host_ready), 32'd0);
    check("t6_both_cpu_reset", 32'(cpu_reset), 32'd1);
    step(); step();
    @(negedge clock);
    check("t6_run_running", 32'(running), 32'd1);
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    @(negedge clock);
    check("t6_start_run_running", 32'(running), 32'd1);
    check("t6_start_run_cycles", run_cycles, 32'd1);
    host_halt = 1'b1;
    step();
    host_halt = 1'b0;
    @(negedge clock);
    check("t6_end_running", 32'(running), 32'd0);
    check("t6_end_run_cycles", run_cycles, 32'd2);
    check("t6_end_timeout", 32'(timeout), 32'd0);

    step(); step(); step();
    @(negedge clock);
    check("pending_reads", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
